wb_regfile: RTL and testbench

- Write-back end of the Y86-64 pipeline. Consumes the W-stage register outputs: stat, icode, valE, valM, dstE and dstM.
- Commits valE/valM into a 15 x 64-bit program register file and serves the two decode-stage read ports.
- Tracks processor status with a sticky RUN/STOP state machine.
- Counts retired instructions for the testbench and performance checks.

---
 rtl/wb_regfile.sv | 118 +++++++++++
 tb/tb_wb_regfile.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Y86-64 write-back stage with a 15 x 64-bit register file, a sticky RUN/STOP status FSM and a retired-instruction counter. Optional macro: WB_BYPASS_EN.
// Writes commit at the clock edge; reads are combinational; status appears one edge after W_stat_i. There is no backpressure: one W-stage slot is consumed every cycle.
module wb_regfile #(
  parameter int REG_NUM = 15,
  parameter int CNT_W   = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       W_stat_i,
  input  logic [3:0]       W_icode_i,
  input  logic [63:0]      W_valE_i,
  input  logic [63:0]      W_valM_i,
  input  logic [3:0]       W_dstE_i,
  input  logic [3:0]       W_dstM_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  output logic [63:0]      d_rvalA_o,
  output logic [63:0]      d_rvalB_o,
  output logic [3:0]       stat_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [3:0] SBUB = 4'd0;
  localparam logic [3:0] SAOK = 4'd1;
  localparam logic [3:0] SADR = 4'd2;
  localparam logic [3:0] SINS = 4'd3;
  localparam logic [3:0] SHLT = 4'd4;

  typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [3:0]       stat_q, stat_d;
  logic             we, retire;
  logic [63:0]      regs [REG_NUM];
  logic [CNT_W-1:0] retired_q;
  logic             a_ok, b_ok;
  logic             icode_unused;

  // icode carries no architectural effect at write-back.
  assign icode_unused = ^W_icode_i;

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    we      = 1'b0;
    retire  = 1'b0;
    if (state_q == ST_RUN) begin
      case (W_stat_i)
        SBUB: stat_d = SAOK;
        SAOK: begin
          we     = 1'b1;
          retire = 1'b1;
          stat_d = SAOK;
        end
        SHLT: begin
          retire  = 1'b1;
          state_d = ST_STOP;
          stat_d  = SHLT;
        end
        SADR: begin
          state_d = ST_STOP;
          stat_d  = SADR;
        end
        default: begin
          state_d = ST_STOP;
          stat_d  = SINS;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      stat_q    <= SAOK;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Port M is checked first so a shared destination takes valM (popq %rsp).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (W_dstM_i == 4'(i))      regs[i] <= W_valM_i;
        else if (W_dstE_i == 4'(i)) regs[i] <= W_valE_i;
      end
    end
  end

  assign a_ok = int'(d_srcA_i) < REG_NUM;
  assign b_ok = int'(d_srcB_i) < REG_NUM;

  always_comb begin
    d_rvalA_o = '0;
    d_rvalB_o = '0;
    if (a_ok) d_rvalA_o = regs[d_srcA_i];
    if (b_ok) d_rvalB_o = regs[d_srcB_i];
`ifdef WB_BYPASS_EN
    // Same-cycle forwarding of the value being committed, M before E.
    if (we && a_ok && W_dstM_i == d_srcA_i)      d_rvalA_o = W_valM_i;
    else if (we && a_ok && W_dstE_i == d_srcA_i) d_rvalA_o = W_valE_i;
    if (we && b_ok && W_dstM_i == d_srcB_i)      d_rvalB_o = W_valM_i;
    else if (we && b_ok && W_dstE_i == d_srcB_i) d_rvalB_o = W_valE_i;
`endif
  end

  assign stat_o    = stat_q;
  assign halted_o  = (state_q == ST_STOP);
  assign retired_o = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile against an architectural model of the Y86-64 write-back stage.
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  W_stat_i = 4'd0, W_icode_i = 4'd0, W_dstE_i = 4'hF, W_dstM_i = 4'hF;
  logic [63:0] W_valE_i = '0, W_valM_i = '0;
  logic [3:0]  d_srcA_i = 4'hF, d_srcB_i = 4'hF;
  logic [63:0] d_rvalA_o, d_rvalB_o;
  logic [3:0]  stat_o;
  logic        halted_o;
  logic [63:0] retired_o;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] m_regs [15];
  bit          m_stop;
  logic [3:0]  m_stat;
  logic [63:0] m_ret;

  wb_regfile #(.REG_NUM(15), .CNT_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .W_stat_i(W_stat_i), .W_icode_i(W_icode_i),
    .W_valE_i(W_valE_i), .W_valM_i(W_valM_i),
    .W_dstE_i(W_dstE_i), .W_dstM_i(W_dstM_i),
    .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
    .stat_o(stat_o), .halted_o(halted_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void m_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_stop = 0;
    m_stat = 4'd1;
    m_ret  = '0;
  endfunction

  // Architectural effect of one W-stage slot.
  function automatic void m_commit();
    if (m_stop) return;
    if (W_stat_i == 4'd1) begin
      if (W_dstE_i != 4'hF) m_regs[W_dstE_i] = W_valE_i;
      if (W_dstM_i != 4'hF) m_regs[W_dstM_i] = W_valM_i;
    end
    if (W_stat_i == 4'd1 || W_stat_i == 4'd4) m_ret = m_ret + 64'd1;
    if (W_stat_i <= 4'd1) m_stat = 4'd1;
    else begin
      m_stop = 1;
      m_stat = (W_stat_i <= 4'd4) ? W_stat_i : 4'd3;
    end
  endfunction

  function automatic logic [63:0] exp_rd(input logic [3:0] a);
    if (a == 4'hF) return 64'h0;
`ifdef WB_BYPASS_EN
    if (!m_stop && W_stat_i == 4'd1) begin
      if (W_dstM_i == a) return W_valM_i;
      if (W_dstE_i == a) return W_valE_i;
    end
`endif
    return m_regs[a];
  endfunction

  task automatic drive(input logic [3:0] s, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
    W_stat_i  = s;
    W_icode_i = 4'($urandom_range(0, 11));
    W_valE_i  = ve;
    W_valM_i  = vm;
    W_dstE_i  = de;
    W_dstM_i  = dm;
  endtask

  // One clock edge; the slot reverts to a bubble afterwards.
  task automatic commit();
    @(posedge clk_i);
    m_commit();
    #1;
    W_stat_i = 4'd0;
    W_dstE_i = 4'hF;
    W_dstM_i = 4'hF;
  endtask

  task automatic pulse_reset();
    #2 rst_i = 1'b1;
    #2 rst_i = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++; if (stat_o !== 4'd1)   begin n_err++; $display("FAIL reset_stat got %0d exp 1", stat_o); end
    n_vec++; if (halted_o !== 1'b0) begin n_err++; $display("FAIL reset_halted got %0b exp 0", halted_o); end
    n_vec++; if (retired_o !== 64'd0) begin n_err++; $display("FAIL reset_retired got %0d exp 0", retired_o); end
    for (int r = 0; r < 16; r++) begin
      d_srcA_i = 4'(r);
      d_srcB_i = 4'(15 - r);
      #1;
      n_vec++; if (d_rvalA_o !== 64'h0) begin n_err++; $display("FAIL reset_rdA[%0d] got %h exp 0", r, d_rvalA_o); end
      n_vec++; if (d_rvalB_o !== 64'h0) begin n_err++; $display("FAIL reset_rdB[%0d] got %h exp 0", 15 - r, d_rvalB_o); end
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_write();
    drive(4'd1, 64'h1234, 64'h0, 4'd3, 4'hF);
    commit();
    d_srcA_i = 4'd3;
    #1;
    n_vec++; if (d_rvalA_o !== 64'h1234) begin n_err++; $display("FAIL write_reg3 got %h exp 1234", d_rvalA_o); end
    n_vec++; if (retired_o !== 64'd1) begin n_err++; $display("FAIL write_retired got %0d exp 1", retired_o); end
    n_vec++; if (stat_o !== 4'd1) begin n_err++; $display("FAIL write_stat got %0d exp 1", stat_o); end
  endtask

  task automatic test_collision();
    drive(4'd1, 64'd8, 64'hAA, 4'd4, 4'd4);
    commit();
    drive(4'd1, 64'h55, 64'h66, 4'd5, 4'd6);
    commit();
    d_srcA_i = 4'd4; d_srcB_i = 4'd5;
    #1;
    n_vec++; if (d_rvalA_o !== 64'hAA) begin n_err++; $display("FAIL collide_reg4 got %h exp aa", d_rvalA_o); end
    n_vec++; if (d_rvalB_o !== 64'h55) begin n_err++; $display("FAIL dual_reg5 got %h exp 55", d_rvalB_o); end
    d_srcA_i = 4'd6;
    #1;
    n_vec++; if (d_rvalA_o !== 64'h66) begin n_err++; $display("FAIL dual_reg6 got %h exp 66", d_rvalA_o); end
  endtask

  task automatic test_bubble();
    logic [63:0] ret0;
    ret0 = retired_o;
    drive(4'd0, 64'd99, 64'd0, 4'd2, 4'hF);
    commit();
    d_srcA_i = 4'd2; d_srcB_i = 4'hF;
    #1;
    n_vec++; if (d_rvalA_o !== m_regs[2]) begin n_err++; $display("FAIL bubble_reg2 got %h exp %h", d_rvalA_o, m_regs[2]); end
    n_vec++; if (d_rvalB_o !== 64'h0) begin n_err++; $display("FAIL rnone_read got %h exp 0", d_rvalB_o); end
    n_vec++; if (retired_o !== ret0) begin n_err++; $display("FAIL bubble_retired got %0d exp %0d", retired_o, ret0); end
    n_vec++; if (stat_o !== 4'd1) begin n_err++; $display("FAIL bubble_stat got %0d exp 1", stat_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) == 0) ? 4'd0 : 4'd1, {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      d_srcA_i = ($urandom_range(0, 1) == 1) ? W_dstM_i : 4'($urandom_range(0, 15));
      d_srcB_i = ($urandom_range(0, 1) == 1) ? W_dstE_i : 4'($urandom_range(0, 15));
      #1;
      n_vec++; if (d_rvalA_o !== exp_rd(d_srcA_i)) begin n_err++; $display("FAIL rand_rdA[%0d] got %h exp %h", d_srcA_i, d_rvalA_o, exp_rd(d_srcA_i)); end
      n_vec++; if (d_rvalB_o !== exp_rd(d_srcB_i)) begin n_err++; $display("FAIL rand_rdB[%0d] got %h exp %h", d_srcB_i, d_rvalB_o, exp_rd(d_srcB_i)); end
      commit();
      n_vec++; if (retired_o !== m_ret) begin n_err++; $display("FAIL rand_retired got %0d exp %0d", retired_o, m_ret); end
      n_vec++; if (stat_o !== m_stat || halted_o !== 1'b0) begin n_err++; $display("FAIL rand_stat got %0d/%0b exp %0d/0", stat_o, halted_o, m_stat); end
    end
  endtask

  task automatic test_halt();
    logic [63:0] ret0;
    ret0 = m_ret;
    drive(4'd4, 64'd0, 64'd0, 4'hF, 4'hF);
    commit();
    n_vec++; if (stat_o !== 4'd4 || halted_o !== 1'b1) begin n_err++; $display("FAIL halt_stat got %0d/%0b exp 4/1", stat_o, halted_o); end
    n_vec++; if (retired_o !== ret0 + 64'd1) begin n_err++; $display("FAIL halt_retired got %0d exp %0d", retired_o, ret0 + 64'd1); end
    for (int n = 0; n < 3; n++) begin
      drive(4'd1, {$urandom, $urandom}, 64'd0, 4'd1, 4'hF);
      d_srcA_i = 4'd1;
      #1;
      n_vec++; if (d_rvalA_o !== m_regs[1]) begin n_err++; $display("FAIL stop_bypass_reg1 got %h exp %h", d_rvalA_o, m_regs[1]); end
      commit();
      #1;
      n_vec++; if (d_rvalA_o !== m_regs[1]) begin n_err++; $display("FAIL stop_reg1 got %h exp %h", d_rvalA_o, m_regs[1]); end
      n_vec++; if (retired_o !== ret0 + 64'd1) begin n_err++; $display("FAIL stop_retired got %0d exp %0d", retired_o, ret0 + 64'd1); end
      n_vec++; if (stat_o !== 4'd4 || halted_o !== 1'b1) begin n_err++; $display("FAIL stop_stat got %0d/%0b exp 4/1", stat_o, halted_o); end
    end
  endtask

  task automatic test_fault();
    pulse_reset();
    drive(4'd1, 64'd0, 64'h42, 4'hF, 4'd7);
    commit();
    drive(4'd2, 64'd0, 64'd5, 4'hF, 4'd7);
    commit();
    d_srcA_i = 4'd7;
    #1;
    n_vec++; if (d_rvalA_o !== 64'h42) begin n_err++; $display("FAIL fault_reg7 got %h exp 42", d_rvalA_o); end
    n_vec++; if (stat_o !== 4'd2 || halted_o !== 1'b1) begin n_err++; $display("FAIL fault_stat got %0d/%0b exp 2/1", stat_o, halted_o); end
    n_vec++; if (retired_o !== 64'd1) begin n_err++; $display("FAIL fault_retired got %0d exp 1", retired_o); end
    #1 rst_i = 1'b1;
    m_reset();
    #1;
    n_vec++; if (stat_o !== 4'd1 || halted_o !== 1'b0) begin n_err++; $display("FAIL async_rst_stat got %0d/%0b exp 1/0", stat_o, halted_o); end
    n_vec++; if (retired_o !== 64'd0) begin n_err++; $display("FAIL async_rst_retired got %0d exp 0", retired_o); end
    for (int r = 0; r < 15; r++) begin
      d_srcA_i = 4'(r);
      #1;
      n_vec++; if (d_rvalA_o !== 64'h0) begin n_err++; $display("FAIL async_rst_reg[%0d] got %h exp 0", r, d_rvalA_o); end
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_unknown_stat();
    drive(4'd9, 64'd1, 64'd2, 4'd0, 4'd1);
    commit();
    d_srcA_i = 4'd1;
    #1;
    n_vec++; if (stat_o !== 4'd3 || halted_o !== 1'b1) begin n_err++; $display("FAIL unknown_stat got %0d/%0b exp 3/1", stat_o, halted_o); end
    n_vec++; if (retired_o !== 64'd0) begin n_err++; $display("FAIL unknown_retired got %0d exp 0", retired_o); end
    n_vec++; if (d_rvalA_o !== 64'h0) begin n_err++; $display("FAIL unknown_reg1 got %h exp 0", d_rvalA_o); end
  endtask

  task automatic test_bypass();
    logic [63:0] exp_pre;
    pulse_reset();
`ifdef WB_BYPASS_EN
    exp_pre = 64'd77;
`else
    exp_pre = 64'd0;
`endif
    drive(4'd1, 64'd0, 64'd77, 4'hF, 4'd9);
    d_srcA_i = 4'd9;
    #1;
    n_vec++; if (d_rvalA_o !== exp_pre) begin n_err++; $display("FAIL bypass_pre got %0d exp %0d", d_rvalA_o, exp_pre); end
    commit();
    #1;
    n_vec++; if (d_rvalA_o !== 64'd77) begin n_err++; $display("FAIL bypass_post got %0d exp 77", d_rvalA_o); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_collision();
    test_bubble();
    test_random();
    test_halt();
    test_fault();
    test_unknown_stat();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
